// File: rtl/const_fetch_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : const_fetch_decode_if
// Brief    : Instruction-in / decoded-constant-out handshake bundle.
// Revision : 1.0
// ============================================================================
interface const_fetch_decode_if #(
    parameter int BITS_PALAVRA = 16,
    parameter int REG_BITS     = 3
);
    logic                    flush;
    logic [BITS_PALAVRA-1:0] in_instr;
    logic                    in_valid;
    logic                    in_ready;
    logic [BITS_PALAVRA-1:0] out_constante;
    logic [1:0]              out_formato;
    logic                    out_R;
    logic [REG_BITS-1:0]     out_rd;
    logic                    out_illegal;
    logic                    out_valid;
    logic                    out_ready;

    // Upstream fetch stage plus downstream consumer.
    modport master (
        output flush, in_instr, in_valid, out_ready,
        input  in_ready, out_constante, out_formato, out_R, out_rd,
               out_illegal, out_valid
    );

    // The decode stage itself.
    modport slave (
        input  flush, in_instr, in_valid, out_ready,
        output in_ready, out_constante, out_formato, out_R, out_rd,
               out_illegal, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/const_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : const_fetch_decode
// Brief    : Decodes loadlit/lcl/lch into constant-ALU operands, 2-entry skid.
// Revision : 1.0
// ============================================================================
module const_fetch_decode #(
    parameter int BITS_PALAVRA = 16,
    parameter int REG_BITS     = 3
) (
    input  wire logic                clock,
    input  wire logic                reset,
    const_fetch_decode_if.slave      bus
);
    typedef struct packed {
        logic [BITS_PALAVRA-1:0] constante;
        logic [1:0]              formato;
        logic                    r;
        logic [REG_BITS-1:0]     rd;
        logic                    illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam entry_t C_ENTRY_ZERO = '0;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t dec;

    logic accept;
    logic issue;

    always_comb begin
        dec         = C_ENTRY_ZERO;
        dec.rd      = bus.in_instr[13:11];
        case (bus.in_instr[15:14])
            2'b10: begin
                dec.constante = {{(BITS_PALAVRA-11){bus.in_instr[10]}}, bus.in_instr[10:0]};
                dec.formato   = 2'b01;
            end
            2'b11: begin
                dec.rd        = bus.in_instr[10:8];
                dec.r         = bus.in_instr[13];
                dec.formato   = 2'b11;
                // Reserved bits flag the word but decoding still proceeds.
                dec.illegal   = (bus.in_instr[12:11] != 2'b00);
                dec.constante = bus.in_instr[13] ? {bus.in_instr[7:0], 8'h00}
                                                 : {8'h00, bus.in_instr[7:0]};
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign issue         = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        head_d  = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = ST_FULL;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (issue) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= C_ENTRY_ZERO;
            skid_q  <= C_ENTRY_ZERO;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_constante = head_q.constante;
    assign bus.out_formato   = head_q.formato;
    assign bus.out_R         = head_q.r;
    assign bus.out_rd        = head_q.rd;
    assign bus.out_illegal   = head_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_const_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_const_fetch_decode
// Brief    : Directed-vector bench for const_fetch_decode.
// Revision : 1.0
// ============================================================================
module tb_const_fetch_decode;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    const_fetch_decode_if #(.BITS_PALAVRA(16), .REG_BITS(3)) bus ();

    const_fetch_decode #(.BITS_PALAVRA(16), .REG_BITS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bus.in_instr = w;
        bus.in_valid = 1'b1;
    endtask

    task automatic expect_head(input string tag, input logic [15:0] c, input logic [1:0] f,
                               input logic r, input logic [2:0] rd, input logic ill);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".const"}, 32'(bus.out_constante), 32'(c));
        check({tag, ".fmt"}, 32'(bus.out_formato), 32'(f));
        check({tag, ".R"}, 32'(bus.out_R), 32'(r));
        check({tag, ".rd"}, 32'(bus.out_rd), 32'(rd));
        check({tag, ".ill"}, 32'(bus.out_illegal), 32'(ill));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_instr  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        expect_idle("rst");
        check("rst.const", 32'(bus.out_constante), 32'd0);
        check("rst.fmt", 32'(bus.out_formato), 32'd0);
        check("rst.R", 32'(bus.out_R), 32'd0);
        check("rst.rd", 32'(bus.out_rd), 32'd0);
        check("rst.ill", 32'(bus.out_illegal), 32'd0);

        // Streamed decodes at full rate with downstream always ready.
        bus.out_ready = 1'b1;
        send(16'h87FF); step(); expect_head("loadlit", 16'hFFFF, 2'b01, 1'b0, 3'd0, 1'b0);
        send(16'hE0AB); step(); expect_head("lch",     16'hAB00, 2'b11, 1'b1, 3'd0, 1'b0);
        send(16'hC5CD); step(); expect_head("lcl",     16'h00CD, 2'b11, 1'b0, 3'd5, 1'b0);
        send(16'h9ABC); step(); expect_head("loadlit+",16'h02BC, 2'b01, 1'b0, 3'd3, 1'b0);
        send(16'h2800); step(); expect_head("nonconst",16'h0000, 2'b00, 1'b0, 3'd5, 1'b0);
        send(16'hD8AB); step(); expect_head("illegal", 16'h00AB, 2'b11, 1'b0, 3'd0, 1'b1);
        bus.in_valid = 1'b0;
        step();
        expect_idle("drain");
        check("drain.hold", 32'(bus.out_constante), 32'h00AB);

        // Stall: A, B fill the buffer; C must wait.
        bus.out_ready = 1'b0;
        send(16'h8001); step();
        check("stall.rdyA", 32'(bus.in_ready), 32'd1);
        expect_head("stall.A", 16'h0001, 2'b01, 1'b0, 3'd0, 1'b0);
        send(16'h9002); step();
        check("stall.rdyB", 32'(bus.in_ready), 32'd0);
        send(16'hA003); step();
        check("stall.rdyC", 32'(bus.in_ready), 32'd0);
        expect_head("stall.holdA", 16'h0001, 2'b01, 1'b0, 3'd0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        expect_head("rel.B", 16'h0002, 2'b01, 1'b0, 3'd2, 1'b0);
        check("rel.rdy", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        expect_head("rel.C", 16'h0003, 2'b01, 1'b0, 3'd4, 1'b0);
        step();
        expect_idle("rel.empty");

        // Flush while FULL with an incoming word.
        bus.out_ready = 1'b0;
        send(16'h8001); step();
        send(16'h9002); step();
        check("flush.full", 32'(bus.in_ready), 32'd0);
        send(16'hA003);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        expect_idle("flush");
        bus.out_ready = 1'b1;
        step();
        expect_idle("flush.stay");
        send(16'hC5CD); step();
        bus.in_valid = 1'b0;
        expect_head("flush.next", 16'h00CD, 2'b11, 1'b0, 3'd5, 1'b0);
        step();
        expect_idle("flush.drain");

        // Reset while holding one stalled entry.
        bus.out_ready = 1'b0;
        send(16'hE0AB); step();
        bus.in_valid = 1'b0;
        check("mid.valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_idle("mid.rst");
        check("mid.const", 32'(bus.out_constante), 32'd0);
        check("mid.fmt", 32'(bus.out_formato), 32'd0);
        check("mid.R", 32'(bus.out_R), 32'd0);
        step();
        expect_idle("mid.empty");
        bus.out_ready = 1'b1;
        send(16'h87FF); step();
        bus.in_valid = 1'b0;
        expect_head("mid.after", 16'hFFFF, 2'b01, 1'b0, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/const_fetch_decode.md
Name: const_fetch_decode

Overview:
- Pipeline stage directly upstream of the constant ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes the constant-class instructions (loadlit, lcl, lch).
- Produces the `constante`, `formato` and `R` operands the constant ALU consumes, plus the destination register index.
- Buffers up to two decoded entries (skid buffer) so an upstream fetch stage can run at full rate despite downstream stalls.

Parameters:
- bits_palavra, 16, data/instruction word width; encoding below is defined for 16 only.
- reg_bits, 3, width of destination register index.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of buffered entries (branch/exception).
- in_instr  input  bits_palavra  instruction word.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  stage can accept a word this cycle.
- out_constante  output  bits_palavra  constant operand for the constant ALU.
- out_formato  output  2  01 = pass value, 11 = byte load, 00 = not a constant op.
- out_R  output  1  byte-load select: 1 = lch (constant in high byte), 0 = lcl.
- out_rd  output  reg_bits  destination register.
- out_illegal  output  1  reserved bits nonzero in a byte-load word.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  downstream accepts the head entry.

Behaviour:
- Decode (combinational on in_instr, registered on accept):
  - [15:14]=10 loadlit: rd=[13:11]; constante = sign-extend([10:0]) to 16 bits; formato=01; R=0.
  - [15:14]=11 byte load: H=[13], rd=[10:8], imm8=[7:0].
    - H=1: constante={imm8,8'h00}, R=1.
    - H=0: constante={8'h00,imm8}, R=0.
    - formato=11.
    - illegal=1 iff [12:11]!=00; fields are still decoded.
  - [15:14]=0x: formato=00, constante=0, R=0, rd=[13:11], illegal=0.
- Transfers:
  - Accept when in_valid && in_ready.
  - Issue when out_valid && out_ready.
- Storage: two entries, head (drives out_*) and skid.
- FSM states: EMPTY, ONE, FULL.
  - EMPTY: accept → ONE (entry into head).
  - ONE: accept without issue → FULL (entry into skid). Issue without accept → EMPTY. Both → ONE (new entry into head).
  - FULL: issue → ONE (skid moves to head). No accept is possible in FULL.
- Outputs:
  - in_ready = (state != FULL); derived from registered state only, no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Latency: a word accepted in cycle N is visible on out_* in cycle N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous issue.
- Ordering: strict FIFO; no entry dropped or duplicated.
- Stability: out_* hold stable while out_valid && !out_ready.
- flush:
  - Next state EMPTY; any accept in the same cycle is discarded.
  - flush has priority over all transfers.
  - in_ready is unaffected in the flush cycle; it is computed from current state.
- Reset: state=EMPTY; out_valid=0, in_ready=1 on the cycle after reset deasserts. out_constante=0, out_formato=00, out_R=0, out_rd=0, out_illegal=0. Reset mid-transfer discards all entries.
- Output values when out_valid=0: hold the last head value (0 after reset); they are don't-care to consumers.

Test Plan:
- Reset, then in 0x8_7FF (10, rd=0, imm11=0x7FF) with out_ready=1 → next cycle out_valid=1, out_constante=0xFFFF, out_formato=01, out_rd=0.
- in 0xE0AB (11, H=1, rd=0, imm8=0xAB) → out_constante=0xAB00, out_formato=11, out_R=1, out_illegal=0. Then 0xC5CD → out_constante=0x00CD, out_R=0, out_rd=5.
- Byte-load word 0xD8AB (bits[12:11]=11) → out_illegal=1; constante still 0x00AB.
- Hold out_ready=0 while streaming words A, B, C → in_ready drops after B, C is not accepted. Release out_ready → A, B, C emerge in order, one per cycle, with no bubble after the first.
- Buffer FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed and the incoming word never appear.
- Assert reset while ONE with out_ready=0 → all outputs 0, out_valid=0 next cycle; a subsequent word decodes normally.
